// File: rtl/clock_pkg.sv
// Shared constants for the game clock generator.
package clock_pkg;

  // Width of the rising-edge counter exposed on edge_count.
  localparam int EDGE_CNT_W = 32;

  // Half-period (in ref_clk cycles) loaded at reset unless overridden.
  localparam int DEFAULT_HALF_PERIOD = 4;

endpackage : clock_pkg

// File: rtl/clock.sv
// Game clock generator: derives a 50%-duty clock from ref_clk with a
// programmable half-period, a one-cycle tick on each rising edge, and a
// free-running count of rising edges. All outputs come straight from flops.
module clock
  import clock_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic                  ref_clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CNT_W-1:0]      half_period,
  output logic                  clk,
  output logic                  tick,
  output logic [EDGE_CNT_W-1:0] edge_count
);

  // A half-period of zero would never terminate a phase, so clamp to one.
  localparam logic [CNT_W-1:0] HP_RESET =
    (HALF_PERIOD < 1) ? CNT_W'(1) : CNT_W'(HALF_PERIOD);

  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [CNT_W-1:0]      hp_q,   hp_d;
  logic                  clk_q,  clk_d;
  logic                  tick_q, tick_d;
  logic [EDGE_CNT_W-1:0] edge_q, edge_d;

  logic running;
  logic phase_end;
  logic rise;

  // Next-state logic: phase counter, toggle, half-period reload and edge count.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    cnt_d  = cnt_q;
    hp_d   = hp_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    edge_d = edge_q;

    // A high phase always runs to completion; a low phase needs en.
    running   = en | clk_q;
    // hp_q is never zero, so hp_q-1 cannot underflow.
    phase_end = running && (cnt_q == (hp_q - CNT_W'(1)));
    rise      = phase_end & ~clk_q;

    if (!running) begin
      // Stopped (or low phase aborted by en=0): restart the low phase later.
      cnt_d = '0;
    end else if (phase_end) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The half-period is sampled only at the rise, so a phase in progress is
    // never stretched or shortened by a change on half_period.
    if (rise) begin
      hp_d   = (half_period == '0) ? CNT_W'(1) : half_period;
      tick_d = 1'b1;
      edge_d = edge_q + EDGE_CNT_W'(1);
    end
  end

  // State registers; reset aborts any phase and clears all outputs at once.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      cnt_q  <= '0;
      hp_q   <= HP_RESET;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hp_q   <= hp_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      edge_q <= edge_d;
    end
  end

  assign clk        = clk_q;
  assign tick       = tick_q;
  assign edge_count = edge_q;

endmodule : clock

// File: tb/tb_clock.sv
// Self-checking bench for the game clock generator: directed scenarios plus a
// randomized run, all compared against a phase-countdown reference model.
module tb_clock;
  import clock_pkg::*;

  localparam int CNT_W = 16;
  localparam int HP0   = DEFAULT_HALF_PERIOD;
  localparam int LIMIT = 200;

  logic                  ref_clk     = 1'b0;
  logic                  rst_n       = 1'b0;
  logic                  en          = 1'b0;
  logic [CNT_W-1:0]      half_period = CNT_W'(HP0);
  logic                  clk;
  logic                  tick;
  logic [EDGE_CNT_W-1:0] edge_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: level of the clock, cycles left in the current phase,
  // active half-period, tick and edge count.
  bit          m_clk;
  bit          m_tick;
  int          m_left;
  int          m_hp;
  logic [31:0] m_edges;

  clock #(
    .CNT_W       (CNT_W),
    .HALF_PERIOD (HP0)
  ) dut (
    .ref_clk     (ref_clk),
    .rst_n       (rst_n),
    .en          (en),
    .half_period (half_period),
    .clk         (clk),
    .tick        (tick),
    .edge_count  (edge_count)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_clk   = 1'b0;
    m_tick  = 1'b0;
    m_edges = '0;
    m_hp    = (HP0 < 1) ? 1 : HP0;
    m_left  = m_hp;
  endtask

  // One ref_clk cycle of the specified behaviour, in terms of phases.
  task automatic model_cycle(input bit run_en, input int hp_in);
    m_tick = 1'b0;
    if (!m_clk && !run_en) begin
      m_left = m_hp;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_clk = !m_clk;
        if (m_clk) begin
          m_hp    = (hp_in == 0) ? 1 : hp_in;
          m_tick  = 1'b1;
          m_edges = m_edges + 32'd1;
        end
        m_left = m_hp;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge ref_clk);
    model_cycle(en, int'(half_period));
    #1;
    check({tag, ".clk"},        32'(clk),   32'(m_clk));
    check({tag, ".tick"},       32'(tick),  32'(m_tick));
    check({tag, ".edge_count"}, edge_count, m_edges);
  endtask

  // Step until clk reaches the given level; n is the number of cycles taken.
  task automatic run_until(input logic level, output int n);
    n = 0;
    do begin
      step("run");
      n++;
    end while (clk !== level && n < LIMIT);
    if (clk !== level) check("run_until_timeout", 32'(clk), 32'(level));
  endtask

  initial begin
    int   n;
    int   first_rise;
    int   tick_a;
    int   tick_b;
    int   toggles;
    int   ticks;
    logic [31:0] frozen;
    logic prev;

    // Reset state, held across clock edges.
    model_reset();
    en          = 1'b1;
    half_period = CNT_W'(4);
    #1;
    check("reset.clk",        32'(clk),  32'd0);
    check("reset.tick",       32'(tick), 32'd0);
    check("reset.edge_count", edge_count, 32'd0);
    repeat (2) @(posedge ref_clk);
    #1;
    check("reset_hold.clk",        32'(clk), 32'd0);
    check("reset_hold.edge_count", edge_count, 32'd0);
    @(negedge ref_clk);
    rst_n = 1'b1;

    // Free running with the reset half-period.
    first_rise = 0;
    tick_a     = 0;
    tick_b     = 0;
    for (int c = 1; c <= 24; c++) begin
      step("start");
      if (clk === 1'b1 && first_rise == 0) first_rise = c;
      if (tick === 1'b1) begin
        if (tick_a == 0) tick_a = c;
        else if (tick_b == 0) tick_b = c;
      end
    end
    check("first_rise_cycle", first_rise, 4);
    check("tick_spacing",     tick_b - tick_a, 8);
    check("edges_after_24",   edge_count, 32'd3);

    // Half-period change during a low phase takes effect at the next rise.
    half_period = CNT_W'(2);
    run_until(1'b1, n);
    check("low_phase_keeps_4", n, 4);
    run_until(1'b0, n);
    check("high_phase_now_2", n, 2);
    run_until(1'b1, n);
    check("low_phase_now_2", n, 2);

    // Zero half-period selects the fastest mode.
    half_period = '0;
    run_until(1'b0, n);
    check("high_before_fast", n, 2);
    run_until(1'b1, n);
    check("low_before_fast", n, 2);
    toggles = 0;
    ticks   = 0;
    prev    = clk;
    for (int c = 0; c < 8; c++) begin
      step("fast");
      if (clk !== prev) toggles++;
      if (tick === 1'b1) ticks++;
      prev = clk;
    end
    check("fast_toggles", toggles, 8);
    check("fast_ticks",   ticks, 4);

    // Stop during a high phase, then restart.
    half_period = CNT_W'(4);
    run_until(1'b0, n);
    run_until(1'b1, n);
    en = 1'b0;
    run_until(1'b0, n);
    check("stop_high_completes", n, 4);
    frozen = edge_count;
    ticks  = 0;
    for (int c = 0; c < 10; c++) begin
      step("stopped");
      if (tick === 1'b1) ticks++;
    end
    check("stopped_no_ticks",  ticks, 0);
    check("stopped_edges",     edge_count, frozen);
    check("stopped_clk_low",   32'(clk), 32'd0);
    en = 1'b1;
    run_until(1'b1, n);
    check("restart_first_rise", n, 4);

    // Randomized enable and half-period traffic against the model.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(7) == 0) en = ~en;
      if ($urandom_range(15) == 0) half_period = CNT_W'($urandom_range(6));
      step("random");
    end

    // Edge counter wrap.
    en          = 1'b1;
    half_period = CNT_W'(3);
    run_until(1'b0, n);
    run_until(1'b1, n);
    force dut.edge_q = 32'hFFFF_FFFF;
    #1;
    release dut.edge_q;
    m_edges = 32'hFFFF_FFFF;
    check("forced_edge_count", edge_count, 32'hFFFF_FFFF);
    run_until(1'b0, n);
    run_until(1'b1, n);
    check("edge_count_wrap", edge_count, 32'd0);

    // Asynchronous reset in the first cycle of a high phase.
    check("tick_before_reset", 32'(tick), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset.clk",        32'(clk),  32'd0);
    check("async_reset.tick",       32'(tick), 32'd0);
    check("async_reset.edge_count", edge_count, 32'd0);
    model_reset();
    half_period = CNT_W'(5);
    @(negedge ref_clk);
    rst_n = 1'b1;
    run_until(1'b1, n);
    check("post_reset_first_rise", n, 4);
    run_until(1'b0, n);
    check("post_reset_high_5", n, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clock

// File: doc/clock.md
CLOCK -- requirements
Module: clock

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the half-period counter and the half_period input.
REQ-002 The module SHALL have parameter HALF_PERIOD, default 4, giving the half-period in ref_clk cycles that is loaded at reset.
REQ-003 The module SHALL have port ref_clk, input, 1 bit: reference clock; all sequential logic runs on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port en, input, 1 bit: run enable for the generated clock.
REQ-006 The module SHALL have port half_period, input, CNT_W bits: requested half-period in ref_clk cycles.
REQ-007 The module SHALL have port clk, output, 1 bit: generated game clock, registered, 50% duty.
REQ-008 The module SHALL have port tick, output, 1 bit: one-ref_clk-cycle pulse marking each clk rising edge.
REQ-009 The module SHALL have port edge_count, output, 32 bits: number of clk rising edges since reset.

Function
REQ-010 The module SHALL keep an internal counter cnt (CNT_W bits) and an active half-period hp_q (CNT_W bits).
REQ-011 While running, cnt SHALL increment every ref_clk cycle; when cnt == hp_q-1, cnt SHALL return to 0 and clk SHALL toggle in that same cycle.
REQ-012 A running clock SHALL therefore have period 2*hp_q ref_clk cycles, with high and low phases of exactly hp_q cycles each.
REQ-013 hp_q SHALL load half_period only in the cycle where clk goes 0->1, so the new value takes effect from that high phase onward; a change never shortens or lengthens a phase already in progress.
REQ-014 When the half_period value to be loaded is 0, hp_q SHALL load 1 (fastest mode: clk toggles every ref_clk cycle).
REQ-015 tick SHALL be 1 for exactly the ref_clk cycle in which clk is first 1 after a 0->1 transition, and 0 otherwise.
REQ-016 edge_count SHALL increment by 1 on every clk 0->1 transition and SHALL wrap from 0xFFFFFFFF to 0.
REQ-017 When en=0 and clk=1, the high phase SHALL complete normally; clk SHALL then go 0 and hold 0, with cnt held at 0.
REQ-018 When en=0 and clk=0, clk SHALL hold 0 and cnt SHALL hold 0; no tick pulses and no edge_count increments SHALL occur while stopped.
REQ-019 When en goes 0->1 from the stopped state, counting SHALL resume from cnt=0; the first clk rise SHALL occur hp_q cycles after the first cycle en is sampled 1.
REQ-020 When en is deasserted during a low phase, the clock SHALL stop immediately (cnt reset to 0); reasserting en SHALL restart the low phase from the beginning.
REQ-021 No combinational path SHALL exist from any input to clk, tick or edge_count (glitch-free outputs).

Reset
REQ-022 On rst_n=0 the module SHALL set clk=0, tick=0, edge_count=0, cnt=0 and hp_q=max(HALF_PERIOD,1), asynchronously.
REQ-023 After rst_n deasserts, the module SHALL apply the en=1 start rule of REQ-019 (first rise after hp_q cycles).
REQ-024 Reset asserted mid-phase SHALL abort the phase with no tick pulse.

Structure
REQ-025 Shared package clock_pkg SHALL hold the 32-bit edge-counter width constant and the default-half-period constant.
REQ-026 The module SHALL be single-level with no sub-modules; the counter, toggle, tick and edge counter are flat registers.

Verification
REQ-027 Scenario: HALF_PERIOD=4, en=1 after reset -> clk rises at ref cycle 4, period 8, tick pulses 8 apart, edge_count=3 after 24 cycles.
REQ-028 Scenario: half_period changed 4->2 during a low phase -> the current low phase stays 4 cycles; phases after the next rise are 2 cycles.
REQ-029 Scenario: half_period=0 -> clk toggles every ref cycle and tick occurs every 2 cycles.
REQ-030 Scenario: en dropped 1 cycle into a high phase of 4 -> clk falls 3 cycles later and stays 0 with edge_count frozen; after en is reasserted, the next rise occurs 4 cycles later.
REQ-031 Scenario: rst_n pulsed low mid high phase -> clk=0, tick=0 and edge_count=0 immediately, without waiting for a ref_clk edge.
REQ-032 Scenario: edge_count preset by force to 0xFFFFFFFF -> the next rise sets it to 0.
